fft_spi_master: RTL and testbench
=================================

Name: fft_spi_master

Overview:
- Controller (initiator) end of the full-duplex frame SPI link used by the FFT peripheral.
- Clocked by `clk`, it generates `sck` and a frame-reset strobe, shifts a FRAME_BITS-wide frame out on `copi` MSB-first, and captures the same number of bits from `cipo`.
- Serves as the bench/loopback initiator and for FPGA-to-FPGA frame transfer.
- Link mode: `copi` changes while `sck` is low; both sides sample on the `sck` rising edge; `sck` idles low.

Parameters:
- FRAME_BITS, 4096: bits per frame; ≥2.
- CLK_DIV, 4: `clk` cycles per `sck` half-period; ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising `clk`
- start  in  1  request a frame transfer; honoured only in IDLE
- tx_frame  in  FRAME_BITS  frame to send; sampled on the cycle `start` is accepted
- busy  out  1  high from the cycle after acceptance through the DONE cycle
- done  out  1  one-cycle pulse when `rx_frame` is updated
- rx_frame  out  FRAME_BITS  last completed received frame, first bit received in the MSB
- sck  out  1  serial clock
- copi  out  1  serial data to peripheral
- cipo  in  1  serial data from peripheral
- frame_rst  out  1  active-high frame reset to peripheral; high except during SHIFT

Behaviour:
- All outputs are registered.
- Reset values: `sck`=0, `copi`=0, `frame_rst`=1, `busy`=0, `done`=0, `rx_frame`=0, state=IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame immediately to reset values. No `done` pulse is produced.
- States: IDLE -> RST -> SHIFT -> DONE -> IDLE.
- Half-period counter `div_cnt` runs 0..CLK_DIV-1. `sck` toggles on the cycle after `div_cnt`==CLK_DIV-1; `div_cnt` then returns to 0.
- IDLE:
  - `sck`=0, `frame_rst`=1.
  - If `start`=1 (cycle T0): load the tx shift register from `tx_frame`, clear the rx shift register, set `bit_cnt`=0, and go to RST.
  - `start` in any other state is ignored; there is no queueing.
- RST:
  - `frame_rst`=1, `copi`=tx MSB.
  - One full `sck` pulse: CLK_DIV cycles low, then CLK_DIV cycles high. `cipo` is not captured.
  - The `sck` falling edge at the end of the pulse coincides with the entry to SHIFT.
  - This pulse gives the peripheral a rising and a falling edge with its reset high, so its frame state clears.
- SHIFT:
  - `frame_rst`=0. Each bit is CLK_DIV cycles low, then CLK_DIV cycles high.
  - On the cycle `sck` goes 0->1: rx_shift <= {rx_shift[FRAME_BITS-2:0], `cipo`}, using the `cipo` value sampled that cycle.
  - On the cycle `sck` goes 1->0: shift tx left by one, put the new MSB on `copi`, and increment `bit_cnt`.
  - After the falling edge of bit FRAME_BITS-1, go to DONE. There is no further `sck` edge.
- DONE (one cycle):
  - `sck`=0, `frame_rst`=1, `done`=1, `busy`=1.
  - `rx_frame` <= final rx_shift, including the last captured bit.
- Timing: `done` is high exactly in cycle T0+1+2·CLK_DIV·(FRAME_BITS+1). `busy` falls the following cycle.
- Back-to-back: `start` held high re-accepts in the first IDLE cycle after DONE, so there is a minimum one-cycle idle gap.
- Counts per frame: FRAME_BITS+1 `sck` rising edges (1 in RST, FRAME_BITS in SHIFT); exactly FRAME_BITS `cipo` captures.
- `rx_frame` is stable between `done` pulses. `tx_frame` changes after T0 have no effect.
- Widths: `bit_cnt` is $clog2(FRAME_BITS+1) bits; `div_cnt` is $clog2(CLK_DIV) bits, minimum 1.

Test Plan:
- Reset/idle: hold `reset`=0 for 3 cycles, then release with FRAME_BITS=16, CLK_DIV=2 -> `sck`=0, `frame_rst`=1, `busy`=0, `done`=0, `rx_frame`=0; no `sck` activity for 50 cycles.
- Loopback (`copi` tied to `cipo`), FRAME_BITS=16, CLK_DIV=2, `tx_frame`=16'hA5C3 -> `done` 1 cycle at T0+69; `rx_frame`=16'hA5C3; 17 `sck` rises counted; `frame_rst` low only during the 16 SHIFT bits.
- Peripheral model (on each `sck` rise, drives 16'h1234 MSB-first on `cipo` after frame reset, and records `copi`), `tx_frame`=16'hBEEF -> model receives 16'hBEEF; `rx_frame`=16'h1234.
- Back-to-back with `start` held high, frames 16'h0001 then 16'h8000 -> two `done` pulses 70 cycles apart; `rx_frame` equals each frame in turn under loopback; `start` pulses mid-frame are ignored.
- Abort: assert `reset`=0 at bit 7 of a frame -> next cycle `sck`=0, `frame_rst`=1, `busy`=0, `rx_frame`=0, no `done`; the next frame completes correctly.
- Default parameters (4096, 4), loopback with an LFSR-seeded frame -> `rx_frame`==`tx_frame`; `done` at T0+1+8·4097.

Source files
------------

// File: rtl/fft_spi_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fft_spi_master_if
// Description : Handshake and serial-link bundle for the FFT frame SPI
//               initiator. The master modport is the initiator's view and
//               the slave modport is the view of whatever drives it.
// Signals     : start     - request a frame transfer
//               tx_frame  - frame to send (sampled when start is accepted)
//               busy      - transfer in progress (through the DONE cycle)
//               done      - one-cycle pulse when rx_frame updates
//               rx_frame  - last completed received frame
//               sck       - serial clock, idles low
//               copi      - serial data to the peripheral, MSB first
//               cipo      - serial data from the peripheral
//               frame_rst - active-high frame reset, low only while shifting
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_spi_master_if #(
  parameter int FRAME_BITS = 4096
) ();
  logic                  start;
  logic [FRAME_BITS-1:0] tx_frame;
  logic                  busy;
  logic                  done;
  logic [FRAME_BITS-1:0] rx_frame;
  logic                  sck;
  logic                  copi;
  logic                  cipo;
  logic                  frame_rst;

  modport master (
    input  start, tx_frame, cipo,
    output busy, done, rx_frame, sck, copi, frame_rst
  );

  modport slave (
    output start, tx_frame, cipo,
    input  busy, done, rx_frame, sck, copi, frame_rst
  );
endinterface
`default_nettype wire

// File: rtl/fft_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fft_spi_master
// Description : Initiator end of the full-duplex frame SPI link. Emits one
//               reset pulse on sck with frame_rst high, then FRAME_BITS data
//               bits: copi changes while sck is low and cipo is captured on
//               each sck rising edge. The received frame is published with a
//               one-cycle done pulse.
// Ports       : clk   - system clock
//               reset - synchronous active-low reset (0 = reset)
//               bus   - fft_spi_master_if.master handshake and serial link
// Parameters  : FRAME_BITS - bits per frame (>= 2)
//               CLK_DIV    - clk cycles per sck half-period (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module fft_spi_master #(
  parameter int FRAME_BITS = 4096,
  parameter int CLK_DIV    = 4
) (
  input  logic               clk,
  input  logic               reset,
  fft_spi_master_if.master   bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RST   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [FRAME_BITS-1:0] r_tx_shift;
  logic [FRAME_BITS-1:0] r_rx_shift;
  logic [FRAME_BITS-1:0] r_rx_frame;
  logic                  r_sck;
  logic                  r_copi;
  logic                  r_frame_rst;
  logic                  r_busy;
  logic                  r_done;

  // Last cycle of an sck half-period: sck toggles on the following edge.
  logic w_half_end;
  assign w_half_end = (r_div_cnt == C_DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_frame  <= '0;
      r_sck       <= 1'b0;
      r_copi      <= 1'b0;
      r_frame_rst <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sck       <= 1'b0;
          r_frame_rst <= 1'b1;
          r_div_cnt   <= '0;
          if (bus.start) begin
            r_tx_shift <= bus.tx_frame;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            // MSB is presented for the whole reset pulse.
            r_copi     <= bus.tx_frame[FRAME_BITS-1];
            r_busy     <= 1'b1;
            r_state    <= S_RST;
          end
        end

        S_RST: begin
          r_copi <= r_tx_shift[FRAME_BITS-1];
          if (w_half_end) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
            // Falling edge ending the reset pulse starts the data phase.
            if (r_sck) begin
              r_frame_rst <= 1'b0;
              r_state     <= S_SHIFT;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_SHIFT: begin
          if (w_half_end) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
            if (!r_sck) begin
              r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], bus.cipo};
            end else begin
              r_tx_shift <= r_tx_shift << 1;
              r_copi     <= r_tx_shift[FRAME_BITS-2];
              r_bit_cnt  <= r_bit_cnt + 1'b1;
              // Last bit's falling edge: publish and pulse done next cycle.
              if (r_bit_cnt == C_BIT_LAST) begin
                r_frame_rst <= 1'b1;
                r_done      <= 1'b1;
                r_rx_frame  <= r_rx_shift;
                r_state     <= S_DONE;
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rx_frame  = r_rx_frame;
  assign bus.sck       = r_sck;
  assign bus.copi      = r_copi;
  assign bus.frame_rst = r_frame_rst;

endmodule
`default_nettype wire

// File: tb/tb_fft_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fft_spi_master
// Description : Self-checking bench for fft_spi_master. A small instance
//               (16 bits, divide by 2) runs table and random frames in
//               loopback or against a peripheral model; a default-size
//               instance runs one loopback frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_spi_master;

  localparam int F    = 16;
  localparam int CD   = 2;
  localparam int FB   = 4096;
  localparam int CDB  = 4;
  // Cycles from the acceptance edge until done is visible (done lands in
  // cycle T0+1+2*CLK_DIV*(FRAME_BITS+1)).
  localparam int LAT  = 2 * CD * (F + 1);
  localparam int LATB = 2 * CDB * (FB + 1);
  localparam int NV   = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft_spi_master_if #(.FRAME_BITS(F)) bus ();
  fft_spi_master #(.FRAME_BITS(F), .CLK_DIV(CD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fft_spi_master_if #(.FRAME_BITS(FB)) bbus ();
  fft_spi_master #(.FRAME_BITS(FB), .CLK_DIV(CDB)) dut_big (
    .clk   (clk),
    .reset (reset),
    .bus   (bbus)
  );
  assign bbus.cipo = bbus.copi;

  bit   loop_en = 1'b1;
  logic per_cipo = 1'b0;
  assign bus.cipo = loop_en ? bus.copi : per_cipo;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  // Peripheral model: cleared while frame_rst is high, records copi on each
  // sck rise and serves per_pat MSB-first on cipo ahead of each rise.
  logic [F-1:0] per_pat = '0;
  logic [F-1:0] per_rec = '0;
  logic [F-1:0] per_got = '0;
  int           per_cnt = 0;
  logic         per_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.frame_rst) begin
      if (per_cnt == F) per_got = per_rec;
      per_cnt = 0;
      per_rec = '0;
    end else if (bus.sck && !per_prev) begin
      per_rec = {per_rec[F-2:0], bus.copi};
      per_cnt++;
    end
    per_prev = bus.sck;
    per_cipo = (per_cnt < F) ? per_pat[4'(F - 1 - per_cnt)] : 1'b0;
  end

  // Activity monitors on the small instance.
  int   rise_tot = 0;
  int   frl_tot  = 0;
  int   done_tot = 0;
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.sck && !mon_prev) rise_tot++;
    if (!bus.frame_rst)       frl_tot++;
    if (bus.done)             done_tot++;
    mon_prev = bus.sck;
  end

  typedef struct {
    logic [F-1:0] tx;
    logic [F-1:0] pat;
    bit           loop;
    logic [F-1:0] exp_rx;
    logic [F-1:0] exp_per;
  } vec_t;
  vec_t vt [NV];

  // Reference: loopback returns what was sent; otherwise the peripheral's
  // pattern comes back and the peripheral sees the transmitted frame.
  function automatic logic [F-1:0] model_rx(input logic [F-1:0] tx,
                                            input logic [F-1:0] pat,
                                            input bit loop);
    return loop ? tx : pat;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int  t_acc, r0, f0, lat;
    bit  seen;
    loop_en = v.loop;
    per_pat = v.pat;
    per_got = '0;
    bus.tx_frame = v.tx;
    bus.start    = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = bus.busy;
    end
    chk({tag, " accept"}, seen, 1'b1);
    t_acc = cyc;
    r0    = rise_tot;
    f0    = frl_tot;
    bus.start    = 1'b0;
    bus.tx_frame = ~v.tx;
    seen = 1'b0;
    for (int k = 0; k < LAT + 20 && !seen; k++) begin
      if (k == 20) bus.start = 1'b1;
      if (k == 22) bus.start = 1'b0;
      tick();
      seen = bus.done;
    end
    lat = cyc - t_acc;
    chk({tag, " done latency"}, lat, LAT);
    chk({tag, " rx_frame"}, bus.rx_frame, v.exp_rx);
    chk({tag, " sck rises"}, rise_tot - r0, F + 1);
    chk({tag, " frame_rst low cycles"}, frl_tot - f0, 2 * CD * F);
    chk({tag, " done-cycle busy/frame_rst"}, {bus.busy, bus.frame_rst}, 2'b11);
    tick();
    chk({tag, " after done busy/done"}, {bus.busy, bus.done}, 2'b00);
    if (!v.loop) chk({tag, " peripheral received"}, per_got, v.exp_per);
  endtask

  initial begin : main
    int           d1, d2, r0, d0;
    bit           seen;
    logic [FB-1:0] big_tx;
    logic [31:0]  lf;
    int           t_acc;

    bus.start     = 1'b0;
    bus.tx_frame  = '0;
    bbus.start    = 1'b0;
    bbus.tx_frame = '0;

    vt[0].tx = 16'hA5C3; vt[0].pat = 16'h0000; vt[0].loop = 1'b1;
    vt[1].tx = 16'hBEEF; vt[1].pat = 16'h1234; vt[1].loop = 1'b0;
    for (int i = 2; i < NV; i++) begin
      vt[i].tx   = 16'($urandom);
      vt[i].pat  = 16'($urandom);
      vt[i].loop = (i % 2) == 0;
    end
    for (int i = 0; i < NV; i++) begin
      vt[i].exp_rx  = model_rx(vt[i].tx, vt[i].pat, vt[i].loop);
      vt[i].exp_per = vt[i].tx;
    end

    // Reset and idle behaviour.
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("reset sck/frame_rst/busy/done", {bus.sck, bus.frame_rst, bus.busy, bus.done}, 4'b0100);
    chk("reset rx_frame", bus.rx_frame, '0);
    chk("reset copi", bus.copi, 1'b0);
    r0 = rise_tot;
    repeat (50) tick();
    chk("idle sck rises", rise_tot - r0, 0);

    for (int i = 0; i < NV; i++) run_frame(vt[i], $sformatf("vec%0d", i));

    // Back-to-back with start held; tx_frame changes after acceptance.
    loop_en = 1'b1;
    bus.tx_frame = 16'h0001;
    bus.start    = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = bus.busy; end
    bus.tx_frame = 16'h8000;
    seen = 1'b0;
    for (int k = 0; k < LAT + 20 && !seen; k++) begin tick(); seen = bus.done; end
    d1 = cyc;
    chk("b2b first done seen", seen, 1'b1);
    chk("b2b first rx", bus.rx_frame, 16'h0001);
    tick();
    seen = 1'b0;
    for (int k = 0; k < LAT + 20 && !seen; k++) begin tick(); seen = bus.done; end
    d2 = cyc;
    bus.start = 1'b0;
    chk("b2b done spacing", d2 - d1, LAT + 2);
    chk("b2b second rx", bus.rx_frame, 16'h8000);
    repeat (3) tick();
    chk("b2b no third frame", bus.busy, 1'b0);

    // Abort during bit 7.
    loop_en = 1'b1;
    bus.tx_frame = 16'hFFFF;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    r0 = rise_tot;
    seen = 1'b0;
    for (int k = 0; k < LAT && !seen; k++) begin tick(); seen = (rise_tot - r0) >= 9; end
    chk("abort reached bit 7", seen, 1'b1);
    d0 = done_tot;
    reset = 1'b0;
    tick();
    chk("abort sck/frame_rst/busy/done", {bus.sck, bus.frame_rst, bus.busy, bus.done}, 4'b0100);
    chk("abort rx_frame", bus.rx_frame, '0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("abort no done", done_tot - d0, 0);
    run_frame('{tx: 16'h3C5A, pat: 16'h0, loop: 1'b1, exp_rx: 16'h3C5A, exp_per: 16'h3C5A},
              "post-abort");

    // Default-size instance, loopback with an LFSR-filled frame.
    lf = $urandom | 32'h1;
    for (int i = 0; i < FB; i++) begin
      lf = {lf[30:0], lf[31] ^ lf[21] ^ lf[1] ^ lf[0]};
      big_tx[i] = lf[0];
    end
    bbus.tx_frame = big_tx;
    bbus.start    = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin tick(); seen = bbus.busy; end
    t_acc = cyc;
    bbus.start    = 1'b0;
    bbus.tx_frame = ~big_tx;
    seen = 1'b0;
    for (int k = 0; k < LATB + 50 && !seen; k++) begin tick(); seen = bbus.done; end
    chk("big done latency", cyc - t_acc, LATB);
    chk("big rx equals tx", bbus.rx_frame == big_tx, 1'b1);
    chk("big rx low word", bbus.rx_frame[63:0], big_tx[63:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
